wire_arith_bank: RTL and testbench

//   Multi-channel arithmetic engine between FrontPanel WireIn and WireOut endpoints.
//   - Each of N_CH channels takes two operands and a 2-bit op mode.
//   - A single-cycle start trigger (from a TriggerIn) launches one batch.
//   - The batch runs all channels in order and publishes every result and flag in one atomic update, marked by a one-cycle done pulse.
//   - Status is also shown on the board LEDs, which are active-low open-drain.

---
 rtl/wire_arith_bank.sv | 195 +++++++++++++++++++
 tb/tb_wire_arith_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wire_arith_bank.sv
// Multi-channel add/sub/accumulate/multiply engine for FrontPanel WireIn/WireOut.
// Each batch walks the channels in order and publishes every result at once.
module wire_arith_bank #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 32,
    parameter int HB_BITS = 24
) (
    input  logic                    okClk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear_acc,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH*WIDTH-1:0]   op_a,
    input  logic [N_CH*WIDTH-1:0]   op_b,
    output logic [N_CH*WIDTH-1:0]   result,
    output logic [N_CH-1:0]         flags,
    output logic                    busy,
    output logic                    done,
    output logic                    dropped,
    output logic [3:0]              led
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MC_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic [1:0]         state;
    logic [CH_W-1:0]    ch;
    logic [MC_W-1:0]    mcnt;
    logic               done_sticky;
    logic [HB_BITS-1:0] hb;

    logic [WIDTH-1:0]   a_q    [N_CH];
    logic [WIDTH-1:0]   b_q    [N_CH];
    logic [1:0]         mode_q [N_CH];
    logic [WIDTH-1:0]   acc    [N_CH];
    logic [WIDTH-1:0]   sh_res [N_CH];
    logic [WIDTH-1:0]   res_q  [N_CH];
    logic [N_CH-1:0]    sh_flag;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH:0] add_c(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // MSB of the extended difference is the unsigned borrow
    function automatic logic [WIDTH:0] sub_b(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    logic [WIDTH-1:0]   cur_a, cur_b, cur_acc;
    logic [1:0]         cur_op;
    logic [2*WIDTH-1:0] p_cur, p_next;
    logic [WIDTH:0]     p_sum;
    logic [WIDTH:0]     r_ext;
    logic [WIDTH-1:0]   ch_res;
    logic               ch_flag;
    logic               ch_fin;
    logic               ch_last;

    assign cur_a   = a_q[ch];
    assign cur_b   = b_q[ch];
    assign cur_op  = mode_q[ch];
    assign cur_acc = acc[ch];

    // Shift-add multiply: {hi, lo} starts as {0, b}; each step adds a into hi when lo[0] is set
    always_comb begin
        p_cur  = (mcnt == '0) ? {{WIDTH{1'b0}}, cur_b} : prod;
        p_sum  = add_c(p_cur[2*WIDTH-1:WIDTH], p_cur[0] ? cur_a : '0);
        p_next = {p_sum, p_cur[WIDTH-1:1]};
    end

    always_comb begin
        r_ext   = '0;
        ch_res  = '0;
        ch_flag = 1'b0;
        ch_fin  = 1'b1;
        case (cur_op)
            OP_ADD: begin
                r_ext   = add_c(cur_a, cur_b);
                ch_res  = r_ext[WIDTH-1:0];
                ch_flag = r_ext[WIDTH];
            end
            OP_SUB: begin
                r_ext   = sub_b(cur_a, cur_b);
                ch_res  = r_ext[WIDTH-1:0];
                ch_flag = r_ext[WIDTH];
            end
            OP_ACC: begin
                r_ext   = add_c(cur_acc, cur_a);
                ch_res  = r_ext[WIDTH-1:0];
                ch_flag = r_ext[WIDTH];
            end
            default: begin
                ch_res  = p_next[WIDTH-1:0];
                ch_flag = |p_next[2*WIDTH-1:WIDTH];
                ch_fin  = (mcnt == MC_W'(WIDTH - 1));
            end
        endcase
        ch_last = ch_fin && (ch == CH_W'(N_CH - 1));
    end

    always_ff @(posedge okClk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ch          <= '0;
            mcnt        <= '0;
            done_sticky <= 1'b0;
            dropped     <= 1'b0;
            hb          <= '0;
            flags       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc[c]   <= '0;
                res_q[c] <= '0;
            end
        end else begin
            hb <= hb + 1'b1;
            case (state)
                S_IDLE: begin
                    if (clear_acc) begin
                        for (int c = 0; c < N_CH; c++) acc[c] <= '0;
                    end
                    if (start) begin
                        state       <= S_CALC;
                        ch          <= '0;
                        mcnt        <= '0;
                        dropped     <= 1'b0;
                        done_sticky <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (start || clear_acc) dropped <= 1'b1;
                    if (cur_op == OP_ACC) acc[ch] <= ch_res;
                    if (ch_fin) begin
                        mcnt <= '0;
                        ch   <= ch_last ? '0 : ch + 1'b1;
                        // Publish atomically; the last channel bypasses its shadow slot
                        if (ch_last) begin
                            state       <= S_DONE;
                            done_sticky <= 1'b1;
                            for (int c = 0; c < N_CH; c++) begin
                                res_q[c] <= (CH_W'(c) == ch) ? ch_res : sh_res[c];
                                flags[c] <= (CH_W'(c) == ch) ? ch_flag : sh_flag[c];
                            end
                        end
                    end else begin
                        mcnt <= mcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (start || clear_acc) dropped <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand snapshot and per-channel working registers
    always_ff @(posedge okClk) begin
        if (state == S_IDLE && start) begin
            for (int c = 0; c < N_CH; c++) begin
                a_q[c]    <= op_a[c*WIDTH +: WIDTH];
                b_q[c]    <= op_b[c*WIDTH +: WIDTH];
                mode_q[c] <= mode[2*c +: 2];
            end
        end
        if (state == S_CALC) begin
            sh_res[ch]  <= ch_res;
            sh_flag[ch] <= ch_flag;
            prod        <= p_next;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_res
        assign result[c*WIDTH +: WIDTH] = res_q[c];
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    assign led[0] = busy          ? 1'b0 : 1'bz;
    assign led[1] = done_sticky   ? 1'b0 : 1'bz;
    assign led[2] = (|flags)      ? 1'b0 : 1'bz;
    assign led[3] = hb[HB_BITS-1] ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_wire_arith_bank.sv
// Self-checking bench for wire_arith_bank: fixed vector table, hand-written corner
// sequences, and random batches against a plain-arithmetic reference model.
module tb_wire_arith_bank;

    localparam int N_CH = 4;
    localparam int W    = 32;

    logic         okClk = 1'b0;
    logic         reset;
    logic         start;
    logic         clear_acc;
    logic [7:0]   mode;
    logic [127:0] op_a, op_b;
    logic [127:0] result;
    logic [3:0]   flags;
    logic         busy, done, dropped;
    wire  [3:0]   led;

    // Board pull-ups: an LED that is off reads back as 1
    pullup pu0 (led[0]);
    pullup pu1 (led[1]);
    pullup pu2 (led[2]);
    pullup pu3 (led[3]);

    wire_arith_bank #(.N_CH(N_CH), .WIDTH(W), .HB_BITS(4)) dut (
        .okClk(okClk), .reset(reset), .start(start), .clear_acc(clear_acc),
        .mode(mode), .op_a(op_a), .op_b(op_b), .result(result), .flags(flags),
        .busy(busy), .done(done), .dropped(dropped), .led(led)
    );

    always #5 okClk = ~okClk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]   md;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] r;
        logic [3:0]   f;
        int           k;
    } vec_t;

    vec_t tbl [4];

    logic [31:0] m_acc [N_CH];

    // Reference: each channel computed directly from its 2-bit op with 64-bit arithmetic
    task automatic model(input logic [7:0] md, input logic [127:0] a, input logic [127:0] b,
                         input logic clr, output logic [127:0] r, output logic [3:0] f, output int k);
        longint unsigned x, y, s;
        r = '0; f = '0; k = 0;
        if (clr) for (int c = 0; c < N_CH; c++) m_acc[c] = '0;
        for (int c = 0; c < N_CH; c++) begin
            x = longint'(a[c*32 +: 32]);
            y = longint'(b[c*32 +: 32]);
            case (md[2*c +: 2])
                2'd0: begin s = x + y; r[c*32 +: 32] = s[31:0]; f[c] = s[32]; k += 1; end
                2'd1: begin s = x - y; r[c*32 +: 32] = s[31:0]; f[c] = (x < y); k += 1; end
                2'd2: begin
                    s = longint'(m_acc[c]) + x;
                    m_acc[c] = s[31:0];
                    r[c*32 +: 32] = s[31:0]; f[c] = s[32]; k += 1;
                end
                default: begin s = x * y; r[c*32 +: 32] = s[31:0]; f[c] = (s[63:32] != 0); k += W; end
            endcase
        end
    endtask

    // Launch one batch and return the number of edges from the start edge to done
    task automatic do_batch(input logic [7:0] md, input logic [127:0] a, input logic [127:0] b,
                            input logic clr, output int k);
        @(negedge okClk);
        mode = md; op_a = a; op_b = b; start = 1'b1; clear_acc = clr;
        @(negedge okClk);
        start = 1'b0; clear_acc = 1'b0;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge okClk); #1;
            if (i == 1) begin
                chk("busy_in_calc", busy, 1'b1);
                chk("led0_on_in_calc", led[0], 1'b0);
            end
            if (done) begin k = i; break; end
        end
        @(posedge okClk); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        logic [127:0] er;
        logic [3:0]   ef;
        int           ek, k, pulses, first;

        tbl[0] = '{8'h00,
                   {32'h12345678, 32'h80000000, 32'h00000002, 32'hFFFFFFFF},
                   {32'h11111111, 32'h80000000, 32'h00000003, 32'h00000001},
                   {32'h23456789, 32'h00000000, 32'h00000005, 32'h00000000},
                   4'b0101, 4};
        tbl[1] = '{8'h34,
                   {32'h00000000, 32'h00010000, 32'h00000005, 32'h00000001},
                   {32'h00000000, 32'h00010000, 32'h00000007, 32'h00000001},
                   {32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000002},
                   4'b0110, 35};
        tbl[2] = '{8'h55,
                   {32'h80000000, 32'h0000000A, 32'h00000000, 32'h00000007},
                   {32'h7FFFFFFF, 32'h00000003, 32'h00000001, 32'h00000007},
                   {32'h00000001, 32'h00000007, 32'hFFFFFFFF, 32'h00000000},
                   4'b0010, 4};
        tbl[3] = '{8'hCF,
                   {32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h00000003},
                   {32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000005},
                   {32'h12345678, 32'h00000000, 32'h00000001, 32'h0000000F},
                   4'b0010, 97};

        for (int c = 0; c < N_CH; c++) m_acc[c] = '0;
        reset = 1'b1; start = 1'b0; clear_acc = 1'b0; mode = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge okClk);
        #1;
        chk("rst_result", result, '0);
        chk("rst_flags", flags, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dropped", dropped, 1'b0);
        chk("rst_led", led, 4'b1111);
        @(negedge okClk); reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            do_batch(tbl[t].md, tbl[t].a, tbl[t].b, 1'b0, k);
            chk($sformatf("tbl%0d_latency", t), k, tbl[t].k);
            chk($sformatf("tbl%0d_result", t), result, tbl[t].r);
            chk($sformatf("tbl%0d_flags", t), flags, tbl[t].f);
        end
        chk("led_idle_sticky_flags", led[2:0], 3'b001);

        // Accumulator: three batches then clear+start together
        @(negedge okClk); clear_acc = 1'b1;
        @(negedge okClk); clear_acc = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            do_batch(8'h80, {32'd3, 96'h0}, '0, 1'b0, k);
            chk($sformatf("acc_run%0d", n), result[127:96], 32'(3 * n));
        end
        do_batch(8'h80, {32'd3, 96'h0}, '0, 1'b1, k);
        chk("acc_clear_with_start", result[127:96], 32'd3);
        chk("acc_clear_latency", k, 4);

        // Start and operand change during a multiply batch
        @(negedge okClk);
        mode = tbl[3].md; op_a = tbl[3].a; op_b = tbl[3].b; start = 1'b1;
        @(negedge okClk); start = 1'b0;
        pulses = 0; first = 0;
        for (int i = 1; i <= 150; i++) begin
            @(posedge okClk); #1;
            if (done) begin pulses++; if (first == 0) first = i; end
            if (i == 10) begin start = 1'b1; op_a = {4{32'hDEADBEEF}}; op_b = {4{32'h0BADF00D}}; end
            if (i == 11) start = 1'b0;
        end
        chk("busy_start_one_done", pulses, 1);
        chk("busy_start_latency", first, 97);
        chk("busy_start_dropped", dropped, 1'b1);
        chk("snapshot_result", result, tbl[3].r);
        chk("snapshot_flags", flags, tbl[3].f);
        do_batch(tbl[0].md, tbl[0].a, tbl[0].b, 1'b0, k);
        chk("dropped_cleared", dropped, 1'b0);
        chk("after_drop_result", result, tbl[0].r);

        // Reset in the middle of a batch
        @(negedge okClk);
        mode = tbl[3].md; op_a = tbl[3].a; op_b = tbl[3].b; start = 1'b1;
        @(negedge okClk); start = 1'b0;
        repeat (20) @(posedge okClk);
        @(negedge okClk); reset = 1'b1;
        #2;
        chk("midrst_result", result, '0);
        chk("midrst_flags", flags, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_led", led, 4'b1111);
        @(negedge okClk); reset = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 120; i++) begin
            @(posedge okClk); #1;
            if (done) pulses++;
            if (i == 7) chk("heartbeat_off", led[3], 1'b1);
            if (i == 8) chk("heartbeat_on", led[3], 1'b0);
        end
        chk("midrst_no_done", pulses, 0);
        chk("midrst_result_hold", result, '0);
        for (int c = 0; c < N_CH; c++) m_acc[c] = '0;

        // Random batches against the reference model
        for (int n = 0; n < 16; n++) begin
            logic [7:0]   md;
            logic [127:0] a, b;
            logic         clr;
            md  = 8'($urandom);
            a   = {$urandom, $urandom, $urandom, $urandom};
            b   = {$urandom, $urandom, $urandom, $urandom};
            if (n % 4 == 1) a[31:0] = 32'hFFFFFFFF;
            clr = ($urandom_range(0, 7) == 0);
            model(md, a, b, clr, er, ef, ek);
            do_batch(md, a, b, clr, k);
            chk($sformatf("rnd%0d_latency", n), k, ek);
            chk($sformatf("rnd%0d_result", n), result, er);
            chk($sformatf("rnd%0d_flags", n), flags, ef);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
